// File: rtl/alu4_issue_ctrl_pkg.sv
// Shared opcode constants, FSM state type and divide-by-zero defaults for the
// ALU4 issue/capture stage.
package alu4_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] DIV0_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  function automatic logic is_div0(input logic [1:0] op, input logic [3:0] b);
    return (op == OP_DIV) && (b == 4'd0);
  endfunction

endpackage

// File: rtl/alu4_issue_ctrl_if.sv
// Bundles the command handshake, the ALU operand/result bus and the result
// handshake; master is the environment side, slave is the issue controller.
interface alu4_issue_ctrl_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] in_opcode;
  logic       in_sel;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_opcode;
  logic       alu_sel;
  logic [7:0] alu_result;
  logic       alu_overflow;
  logic       alu_carry;
  logic [3:0] alu_remainder;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_overflow;
  logic       out_carry;
  logic [3:0] out_remainder;
  logic [1:0] out_opcode;
  logic       out_div0;

  modport master (
    output in_valid, in_a, in_b, in_opcode, in_sel,
    output alu_result, alu_overflow, alu_carry, alu_remainder,
    output out_ready,
    input  in_ready,
    input  alu_a, alu_b, alu_opcode, alu_sel,
    input  out_valid, out_result, out_overflow, out_carry, out_remainder,
    input  out_opcode, out_div0
  );

  modport slave (
    input  in_valid, in_a, in_b, in_opcode, in_sel,
    input  alu_result, alu_overflow, alu_carry, alu_remainder,
    input  out_ready,
    output in_ready,
    output alu_a, alu_b, alu_opcode, alu_sel,
    output out_valid, out_result, out_overflow, out_carry, out_remainder,
    output out_opcode, out_div0
  );

endinterface

// File: rtl/alu4_issue_ctrl_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module alu4_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/alu4_issue_ctrl.sv
// Issue/capture stage around the combinational 4-bit ALU, with divide-by-zero
// override and error count. Optional ALU4_ISSUE_STATS_EN adds an ops_done counter.
module alu4_issue_ctrl
  import alu4_pkg::*;
#(
  parameter int         ERR_CNT_W   = 8,
  parameter logic [7:0] DIV0_RESULT = DIV0_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu4_issue_ctrl_if.slave     bus,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef ALU4_ISSUE_STATS_EN
  ,
  output logic [15:0]          ops_done
`endif
);

  state_t r_state;
  state_t w_state_next;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_capture;
  logic       w_release;
  logic       w_div0;
  logic       w_err_inc;

  logic [3:0] r_alu_a;
  logic [3:0] r_alu_b;
  logic [1:0] r_alu_opcode;
  logic       r_alu_sel;

  logic       r_out_valid;
  logic [7:0] r_out_result;
  logic       r_out_overflow;
  logic       r_out_carry;
  logic [3:0] r_out_remainder;
  logic [1:0] r_out_opcode;
  logic       r_out_div0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // In HOLD the slot frees up on the same edge the result is taken, so a new
  // command can be accepted in that cycle.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept     = 1'b1;
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_capture    = 1'b1;
        w_state_next = HOLD;
      end
      HOLD: begin
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          w_release = 1'b1;
          if (bus.in_valid) begin
            w_accept     = 1'b1;
            w_state_next = CAPTURE;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_alu_sel    <= 1'b0;
    end else if (w_accept) begin
      r_alu_a      <= bus.in_a;
      r_alu_b      <= bus.in_b;
      r_alu_opcode <= bus.in_opcode;
      r_alu_sel    <= bus.in_sel;
    end
  end

  assign w_div0    = is_div0(r_alu_opcode, r_alu_b);
  assign w_err_inc = w_capture && w_div0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_result    <= '0;
      r_out_overflow  <= 1'b0;
      r_out_carry     <= 1'b0;
      r_out_remainder <= '0;
      r_out_opcode    <= '0;
      r_out_div0      <= 1'b0;
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_opcode <= r_alu_opcode;
      r_out_div0   <= w_div0;
      if (w_div0) begin
        r_out_result    <= DIV0_RESULT;
        r_out_overflow  <= 1'b1;
        r_out_carry     <= 1'b0;
        r_out_remainder <= r_alu_a;
      end else begin
        r_out_result    <= bus.alu_result;
        r_out_overflow  <= bus.alu_overflow;
        r_out_carry     <= bus.alu_carry;
        r_out_remainder <= bus.alu_remainder;
      end
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  alu4_sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .inc   (w_err_inc),
    .count (err_count)
  );

`ifdef ALU4_ISSUE_STATS_EN
  logic [15:0] r_ops_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ops_done <= '0;
    end else if (r_out_valid && bus.out_ready) begin
      r_ops_done <= r_ops_done + 16'd1;
    end
  end

  assign ops_done = r_ops_done;
`endif

  assign bus.in_ready      = w_in_ready;
  assign bus.alu_a         = r_alu_a;
  assign bus.alu_b         = r_alu_b;
  assign bus.alu_opcode    = r_alu_opcode;
  assign bus.alu_sel       = r_alu_sel;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_result    = r_out_result;
  assign bus.out_overflow  = r_out_overflow;
  assign bus.out_carry     = r_out_carry;
  assign bus.out_remainder = r_out_remainder;
  assign bus.out_opcode    = r_out_opcode;
  assign bus.out_div0      = r_out_div0;

endmodule

// File: tb/tb_alu4_issue_ctrl.sv
// Testbench for alu4_issue_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model; a stand-in ALU closes the loop.
module tb_alu4_issue_ctrl;
  import alu4_pkg::*;

  typedef struct packed {
    logic [7:0] r;
    logic       ov;
    logic       cy;
    logic [3:0] rem;
  } alu_o_t;

  typedef struct packed {
    logic [7:0] r;
    logic       ov;
    logic       cy;
    logic [3:0] rem;
    logic [1:0] op;
    logic       div0;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] err_count;
`ifdef ALU4_ISSUE_STATS_EN
  logic [15:0] ops_done;
`endif
  int tests_run    = 0;
  int tests_failed = 0;
  alu_o_t w_alu;

  alu4_issue_ctrl_if bus ();

  alu4_issue_ctrl #(
    .ERR_CNT_W   (8),
    .DIV0_RESULT (8'hFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err_count (err_count)
`ifdef ALU4_ISSUE_STATS_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational ALU; garbage on divide-by-zero on purpose.
  function automatic alu_o_t alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    alu_o_t o;
    logic [4:0] s;
    o = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = {3'b000, s};
        o.cy = s[4];
        o.ov = (a[3] == b[3]) && (s[3] != a[3]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        o.r = {4'h0, a} - {4'h0, b};
        o.cy = (a < b);
        o.ov = (a[3] != b[3]) && (s[3] != a[3]);
      end
      OP_MUL: begin
        o.r = {4'h0, a} * {4'h0, b};
        o.ov = (o.r > 8'd15);
      end
      default: begin
        if (b != 4'd0) begin
          o.r = {4'h0, a / b};
          o.rem = a % b;
        end else begin
          o.r = 8'hA5; o.cy = 1'b1; o.rem = 4'h3;
        end
      end
    endcase
    return o;
  endfunction

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    exp_t e;
    alu_o_t o;
    e.op = op;
    if (op == 2'b11 && b == 4'd0) begin
      e.r = 8'hFF; e.ov = 1'b1; e.cy = 1'b0; e.rem = a; e.div0 = 1'b1;
    end else begin
      o = alu_fn(a, b, op);
      e.r = o.r; e.ov = o.ov; e.cy = o.cy; e.rem = o.rem; e.div0 = 1'b0;
    end
    return e;
  endfunction

  always_comb w_alu = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
  assign bus.alu_result    = w_alu.r;
  assign bus.alu_overflow  = w_alu.ov;
  assign bus.alu_carry     = w_alu.cy;
  assign bus.alu_remainder = w_alu.rem;

  task automatic set_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic sel);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_opcode = op; bus.in_sel = sel;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_opcode = '0; bus.in_sel = 1'b0;
    tick(); tick();
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    tests_run++; if (bus.out_valid !== 1'b0 || err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_out got valid=%b err=%0d want 0/0", bus.out_valid, err_count); end
    tests_run++; if ({bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_sel} !== 11'd0 || {bus.out_result, bus.out_remainder, bus.out_div0} !== 13'd0) begin
      tests_failed++; $display("FAIL reset_regs got alu=%h out=%h want 0", {bus.alu_a, bus.alu_b, bus.alu_opcode, bus.alu_sel}, {bus.out_result, bus.out_remainder, bus.out_div0}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    set_cmd(4'd5, 4'd3, OP_ADD, 1'b1); bus.out_ready = 1'b0; #1;
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL add_ready got %b want 1", bus.in_ready); end
    tick(); bus.in_valid = 1'b0;
    tests_run++; if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.out_valid, bus.in_ready} !== {4'd5, 4'd3, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL add_issue got a=%0d b=%0d sel=%b ov=%b rdy=%b want 5 3 1 0 0", bus.alu_a, bus.alu_b, bus.alu_sel, bus.out_valid, bus.in_ready); end
    tick();
    tests_run++; if ({bus.out_valid, bus.out_result, bus.out_div0, bus.out_opcode} !== {1'b1, 8'd8, 1'b0, OP_ADD} || err_count !== 8'd0) begin
      tests_failed++; $display("FAIL add_result got v=%b r=%0d d0=%b err=%0d want 1 8 0 0", bus.out_valid, bus.out_result, bus.out_div0, err_count); end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_release got %b want 0", bus.out_valid); end
  endtask

  task automatic test_hold();
    set_cmd(4'd15, 4'd1, OP_ADD, 1'b0); bus.out_ready = 1'b0;
    tick(); bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if ({bus.out_valid, bus.out_result, bus.out_carry, bus.in_ready, bus.alu_a} !== {1'b1, 8'd16, 1'b1, 1'b0, 4'd15}) begin
        tests_failed++; $display("FAIL hold_stable[%0d] got v=%b r=%0d c=%b rdy=%b a=%0d want 1 16 1 0 15", i, bus.out_valid, bus.out_result, bus.out_carry, bus.in_ready, bus.alu_a); end
    end
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; #1;
    tests_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_to_idle got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    set_cmd(4'd2, 4'd3, OP_MUL, 1'b0); bus.out_ready = 1'b1;
    tick(); set_cmd(4'd15, 4'd3, OP_MUL, 1'b0);
    tick();
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'd6) begin tests_failed++; $display("FAIL b2b_first got v=%b r=%0d want 1 6", bus.out_valid, bus.out_result); end
    tick(); bus.in_valid = 1'b0;
    tests_run++; if (bus.out_valid !== 1'b0 || bus.alu_a !== 4'd15) begin tests_failed++; $display("FAIL b2b_accept got v=%b a=%0d want 0 15", bus.out_valid, bus.alu_a); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'd45 || bus.out_overflow !== 1'b1) begin tests_failed++; $display("FAIL b2b_second got v=%b r=%0d ov=%b want 1 45 1", bus.out_valid, bus.out_result, bus.out_overflow); end
    tick(); bus.out_ready = 1'b0;
  endtask

  task automatic test_div0_saturate();
    int acc;
    set_cmd(4'd10, 4'd0, OP_DIV, 1'b0); bus.out_ready = 1'b0;
    tick(); bus.in_valid = 1'b0;
    tick();
    tests_run++; if ({bus.out_result, bus.out_remainder, bus.out_div0, bus.out_overflow, bus.out_carry} !== {8'hFF, 4'd10, 1'b1, 1'b1, 1'b0} || err_count !== 8'd1) begin
      tests_failed++; $display("FAIL div0_first got r=%h rem=%0d d0=%b ov=%b c=%b err=%0d want ff 10 1 1 0 1", bus.out_result, bus.out_remainder, bus.out_div0, bus.out_overflow, bus.out_carry, err_count); end
    set_cmd(4'd10, 4'd0, OP_DIV, 1'b0); bus.out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 2000 && acc < 299; c++) begin
      #1; if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    tests_run++; if (acc !== 299) begin tests_failed++; $display("FAIL div0_accepts got %0d want 299", acc); end
    tick(); tick(); tick();
    tests_run++; if (err_count !== 8'd255) begin tests_failed++; $display("FAIL div0_saturate got %0d want 255", err_count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_div_reset();
    set_cmd(4'd10, 4'd2, OP_DIV, 1'b0); bus.out_ready = 1'b0;
    tick(); bus.in_valid = 1'b0;
    tick();
    tests_run++; if ({bus.out_result, bus.out_remainder, bus.out_div0} !== {8'd5, 4'd0, 1'b0}) begin
      tests_failed++; $display("FAIL div_normal got r=%0d rem=%0d d0=%b want 5 0 0", bus.out_result, bus.out_remainder, bus.out_div0); end
    #2; rst_n = 1'b0; #1;
    tests_run++; if (bus.out_valid !== 1'b0 || err_count !== 8'd0 || bus.alu_a !== 4'd0 || bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL async_reset got v=%b err=%0d a=%0d rdy=%b want 0 0 0 1", bus.out_valid, err_count, bus.alu_a, bus.in_ready); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, got, snap;
    logic have_snap, acc;
    int err_model, hs;
    err_model = 0; hs = 0; have_snap = 1'b0;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!bus.in_valid && cyc < 780 && $urandom_range(0, 3) != 0) begin
        set_cmd(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom), 2'($urandom), 1'($urandom));
      end
      bus.out_ready = (cyc >= 780) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      got = {bus.out_result, bus.out_overflow, bus.out_carry, bus.out_remainder, bus.out_opcode, bus.out_div0};
      if (have_snap && bus.out_valid) begin
        tests_run++; if (got !== snap) begin tests_failed++; $display("FAIL rand_stable got %h want %h", got, snap); end
      end
      have_snap = bus.out_valid && !bus.out_ready;
      snap = got;
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++; $display("FAIL rand_unexpected got %h want none", got);
        end else begin
          e = q.pop_front();
          if (e.div0 && err_model < 255) err_model++;
          hs++;
          $display("[TB] txn %0d result=%h ov=%b cy=%b rem=%h op=%0d div0=%b err=%0d", hs, got.r, got.ov, got.cy, got.rem, got.op, got.div0, err_count);
          if (got !== e) begin tests_failed++; $display("FAIL rand_result got %h want %h", got, e); end
          tests_run++; if (err_count !== 8'(err_model)) begin tests_failed++; $display("FAIL rand_err got %0d want %0d", err_count, err_model); end
        end
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) q.push_back(model(bus.in_a, bus.in_b, bus.in_opcode));
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
    end
    tests_run++; if (q.size() != 0 || hs < 50) begin tests_failed++; $display("FAIL rand_drain got pending=%0d done=%0d want 0 >=50", q.size(), hs); end
    bus.out_ready = 1'b0;
  endtask

`ifdef ALU4_ISSUE_STATS_EN
  task automatic test_stats();
    int acc;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    set_cmd(4'd1, 4'd2, OP_ADD, 1'b0); bus.out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 100 && acc < 4; c++) begin
      #1; if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    tests_run++; if (ops_done !== 16'd4) begin tests_failed++; $display("FAIL stats_done got %0d want 4", ops_done); end
    bus.out_ready = 1'b0; set_cmd(4'd3, 4'd3, OP_SUB, 1'b0);
    tick(); set_cmd(4'd4, 4'd4, OP_SUB, 1'b0);
    tick(); tick(); tick(); tick();
    tests_run++; if (ops_done !== 16'd4) begin tests_failed++; $display("FAIL stats_unconsumed got %0d want 4", ops_done); end
    bus.in_valid = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_hold();
    test_back_to_back();
    test_div0_saturate();
    test_div_reset();
    test_random();
`ifdef ALU4_ISSUE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
